// File: rtl/hamming_link_pkg.sv
// Shared types and constants for the Hamming link transmit path.
package hamming_link_pkg;

    localparam int unsigned WORD_W_DEF = 32;
    localparam int unsigned GAP_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } tx_sched_state_t;

    // A 1-bit word still needs a 1-bit counter.
    function automatic int unsigned bit_cnt_width(input int unsigned word_w);
        return (word_w > 1) ? $clog2(word_w) : 1;
    endfunction

    localparam int unsigned BIT_CNT_W = bit_cnt_width(WORD_W_DEF);

endpackage

// File: rtl/hamming_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last grant.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hamming_tx_scheduler.sv
// Round-robin word scheduler that serializes granted words MSB-first
// into the Hamming encoder's bit-serial input, honouring its backpressure.
module hamming_tx_scheduler
    import hamming_link_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned WORD_W     = WORD_W_DEF,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic                        clk_in,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*WORD_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        enc_data_in,
    output logic                        enc_data_valid,
    input  logic                        enc_data_in_ready,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        word_done,
    output logic [15:0]                 words_sent
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = bit_cnt_width(WORD_W);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYCLES - 1);

    tx_sched_state_t          state_q, state_d;
    logic [WORD_W-1:0]        shreg_q;
    logic [CNT_W-1:0]         bit_cnt_q;
    logic [GAP_CNT_W-1:0]     gap_cnt_q;
    logic [IDX_W-1:0]         last_grant_q;
    logic [IDX_W-1:0]         grant_id_q;
    logic                     word_done_q;
    logic [15:0]              words_sent_q;

    logic [NUM_REQ-1:0]       arb_req;
    logic [NUM_REQ-1:0]       arb_grant;
    logic [IDX_W-1:0]         arb_idx;
    logic                     arb_any;
    logic                     accept;
    logic                     last_bit;
    logic [WORD_W-1:0]        load_word;

    always_comb begin
        arb_req = enable ? req_valid : '0;
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (arb_req),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any        (arb_any)
    );

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        last_bit = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    accept  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (enc_data_in_ready && bit_cnt_q == LAST_BIT) begin
                    last_bit = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                    end else if (arb_any) begin
                        // Back-to-back reload keeps valid high with no bubble.
                        accept  = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset also masks the combinational accept so no grant is seen while held.
    always_comb begin
        req_ready = (accept && !rst) ? arb_grant : '0;
        load_word = req_data[int'(arb_idx) * WORD_W +: WORD_W];
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            word_done_q  <= 1'b0;
            words_sent_q <= '0;
        end else begin
            state_q     <= state_d;
            word_done_q <= last_bit;
            if (last_bit) begin
                words_sent_q <= words_sent_q + 16'd1;
            end
            if (state_q == ST_GAP) begin
                gap_cnt_q <= gap_cnt_q + 8'd1;
            end else begin
                gap_cnt_q <= '0;
            end
            if (accept) begin
                shreg_q      <= load_word;
                bit_cnt_q    <= '0;
                grant_id_q   <= arb_idx;
                last_grant_q <= arb_idx;
            end else if (state_q == ST_SHIFT && enc_data_in_ready) begin
                shreg_q   <= shreg_q << 1;
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        enc_data_valid = (state_q == ST_SHIFT);
        enc_data_in    = (state_q == ST_SHIFT) && shreg_q[WORD_W-1];
        busy           = (state_q != ST_IDLE);
        grant_id       = grant_id_q;
        word_done      = word_done_q;
        words_sent     = words_sent_q;
    end

endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// Directed bench for hamming_tx_scheduler: arbitration table, serial data,
// backpressure, enable drop, mid-word reset, gap timing and counter wrap.
module tb_hamming_tx_scheduler;
    localparam int unsigned N = 4;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // main DUT: GAP_CYCLES = 0
    logic           rst = 1'b0;
    logic           enable, rdy;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_data;
    logic           dout, dvalid, busy, wdone;
    logic [1:0]     gid;
    logic [15:0]    wsent;

    hamming_tx_scheduler #(.NUM_REQ(4), .WORD_W(32), .GAP_CYCLES(0)) dut (
        .clk_in(clk), .rst(rst), .enable(enable), .req_valid(req_valid),
        .req_data(req_data), .req_ready(req_ready), .enc_data_in(dout),
        .enc_data_valid(dvalid), .enc_data_in_ready(rdy), .grant_id(gid),
        .busy(busy), .word_done(wdone), .words_sent(wsent)
    );

    // gap DUT: GAP_CYCLES = 3
    logic           g_enable, g_rdy;
    logic [N-1:0]   g_req_valid, g_req_ready;
    logic [N*W-1:0] g_req_data;
    logic           g_dout, g_dvalid, g_busy, g_wdone;
    logic [1:0]     g_gid;
    logic [15:0]    g_wsent;

    hamming_tx_scheduler #(.NUM_REQ(4), .WORD_W(32), .GAP_CYCLES(3)) dut_gap (
        .clk_in(clk), .rst(rst), .enable(g_enable), .req_valid(g_req_valid),
        .req_data(g_req_data), .req_ready(g_req_ready), .enc_data_in(g_dout),
        .enc_data_valid(g_dvalid), .enc_data_in_ready(g_rdy), .grant_id(g_gid),
        .busy(g_busy), .word_done(g_wdone), .words_sent(g_wsent)
    );

    // wrap DUT: 1-bit words so the 16-bit counter wraps in ~64k cycles
    logic           w_enable, w_rdy;
    logic [1:0]     w_req_valid, w_req_ready, w_req_data;
    logic           w_dout, w_dvalid, w_busy, w_wdone;
    logic [0:0]     w_gid;
    logic [15:0]    w_wsent;

    hamming_tx_scheduler #(.NUM_REQ(2), .WORD_W(1), .GAP_CYCLES(0)) dut_wrap (
        .clk_in(clk), .rst(rst), .enable(w_enable), .req_valid(w_req_valid),
        .req_data(w_req_data), .req_ready(w_req_ready), .enc_data_in(w_dout),
        .enc_data_valid(w_dvalid), .enc_data_in_ready(w_rdy), .grant_id(w_gid),
        .busy(w_busy), .word_done(w_wdone), .words_sent(w_wsent)
    );

    typedef struct {
        logic [N-1:0] mask;
        logic         en;
        logic [N-1:0] exp_ready;
    } vec_t;

    vec_t        vecs[9];
    logic [31:0] words[4];
    int          exp_sent;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] got;
        logic        valid_ok;
        int          g;
        @(negedge clk);
        req_valid = v.mask;
        enable    = v.en;
        #1;
        check("vec_ready", 32'(req_ready), 32'(v.exp_ready));
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        enable    = 1'b0;
        if (v.exp_ready == '0) begin
            check("vec_no_grant_busy", 32'(busy), 0);
        end else begin
            g = 0;
            for (int i = 0; i < N; i++) if (v.exp_ready[i]) g = i;
            check("vec_gid", 32'(gid), g);
            got      = '0;
            valid_ok = 1'b1;
            for (int b = 0; b < W; b++) begin
                if (!dvalid) valid_ok = 1'b0;
                got = {got[30:0], dout};
                @(negedge clk);
            end
            exp_sent++;
            check("vec_valid", 32'(valid_ok), 1);
            check("vec_word", got, words[g]);
            check("vec_done", 32'(wdone), 1);
            check("vec_sent", 32'(wsent), exp_sent);
        end
    endtask

    initial begin : main
        logic [31:0] got;
        logic        hold_ok, gap_ready_bad;
        int          bubbles, zeros, wcount;

        words[0] = 32'h6748CC61;
        words[1] = 32'hA5A5F00F;
        words[2] = 32'h80000001;
        words[3] = 32'hDEADBEEF;
        req_data   = {words[3], words[2], words[1], words[0]};
        g_req_data = req_data;
        w_req_data = 2'b01;
        enable = 1'b1; req_valid = 4'hF; rdy = 1'b1;
        g_enable = 1'b0; g_req_valid = '0; g_rdy = 1'b1;
        w_enable = 1'b0; w_req_valid = '0; w_rdy = 1'b1;
        exp_sent = 0;

        vecs[0] = '{4'b0001, 1'b1, 4'b0001};
        vecs[1] = '{4'b1111, 1'b1, 4'b0010};
        vecs[2] = '{4'b1001, 1'b1, 4'b1000};
        vecs[3] = '{4'b0110, 1'b1, 4'b0010};
        vecs[4] = '{4'b0001, 1'b1, 4'b0001};
        vecs[5] = '{4'b1100, 1'b1, 4'b0100};
        vecs[6] = '{4'b0000, 1'b1, 4'b0000};
        vecs[7] = '{4'b1111, 1'b0, 4'b0000};
        vecs[8] = '{4'b1010, 1'b1, 4'b1000};

        // reset state, with requests pending while reset is held
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_valid", 32'(dvalid), 0);
        check("rst_dout", 32'(dout), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(wdone), 0);
        check("rst_sent", 32'(wsent), 0);
        check("rst_gid", 32'(gid), 0);
        req_valid = '0; enable = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // round-robin, all valid, back-to-back
        @(negedge clk);
        rst = 1'b1; #2 rst = 1'b0;
        exp_sent  = 0;
        req_valid = 4'hF; enable = 1'b1;
        #1;
        check("rr_first_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        bubbles = 0;
        for (int c = 0; c < 160; c++) begin
            if (c == 159) enable = 1'b0;
            #1;
            if (!dvalid) bubbles++;
            if (c % 32 == 0) check("rr_gid", 32'(gid), (c / 32) % 4);
            if (c % 32 == 31)
                check("rr_ready", 32'(req_ready), (c == 159) ? 0 : (1 << ((c / 32 + 1) % 4)));
            @(negedge clk);
        end
        exp_sent += 5;
        req_valid = '0;
        check("rr_bubbles", bubbles, 0);
        check("rr_done", 32'(wdone), 1);
        check("rr_sent", 32'(wsent), exp_sent);
        check("rr_idle", 32'(busy), 0);

        // backpressure: ready low for word cycles 5..9
        @(negedge clk);
        req_valid = 4'b0010; enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = '0; enable = 1'b0;
        got = '0; hold_ok = 1'b1;
        for (int k = 0; k < 37; k++) begin
            rdy = (k >= 5 && k <= 9) ? 1'b0 : 1'b1;
            #1;
            if (k >= 5 && k <= 9) begin
                if (dout !== words[1][26] || dvalid !== 1'b1) hold_ok = 1'b0;
            end else begin
                got = {got[30:0], dout};
            end
            if (k == 36) check("bp_not_done_early", 32'(wdone), 0);
            @(negedge clk);
        end
        rdy = 1'b1;
        exp_sent++;
        check("bp_hold", 32'(hold_ok), 1);
        check("bp_word", got, words[1]);
        check("bp_done", 32'(wdone), 1);
        check("bp_sent", 32'(wsent), exp_sent);

        // enable dropped at bit 10 while requests stay pending
        @(negedge clk);
        req_valid = 4'b1100; enable = 1'b1;
        #1;
        check("en_ready", 32'(req_ready), 32'h4);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 32; k++) begin
            if (k == 10) enable = 1'b0;
            #1;
            if (k == 31) check("en_last_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        exp_sent++;
        check("en_done", 32'(wdone), 1);
        check("en_sent", 32'(wsent), exp_sent);
        @(negedge clk);
        check("en_no_regrant", 32'({dvalid, busy, req_ready}), 0);
        req_valid = '0;

        // reset at bit 17 of a word from requester 3
        @(negedge clk);
        req_valid = 4'hF; enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mr_gid", 32'(gid), 3);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mr_valid", 32'(dvalid), 0);
        check("mr_dout", 32'(dout), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_gid0", 32'(gid), 0);
        check("mr_sent", 32'(wsent), 0);
        check("mr_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mr_prio0", 32'(req_ready), 32'h1);
        enable = 1'b0; req_valid = '0;

        // gap of 3 plus one IDLE arbitration cycle
        @(negedge clk);
        g_req_valid = 4'b0011; g_enable = 1'b1;
        #1;
        check("gap_ready0", 32'(g_req_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        check("gap_gid0", 32'(g_gid), 0);
        repeat (32) @(negedge clk);
        zeros = 0; gap_ready_bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (g_dvalid) break;
            zeros++;
            if (zeros == 1) check("gap_done", 32'(g_wdone), 1);
            if (zeros <= 3 && g_req_ready != '0) gap_ready_bad = 1'b1;
            if (zeros == 4) check("gap_idle_ready", 32'(g_req_ready), 32'h2);
            @(negedge clk);
        end
        g_req_valid = '0; g_enable = 1'b0;
        check("gap_zero_cycles", zeros, 4);
        check("gap_no_ready", 32'(gap_ready_bad), 0);
        check("gap_gid1", 32'(g_gid), 1);

        // words_sent wrap on 1-bit words
        @(negedge clk);
        w_req_valid = 2'b01; w_enable = 1'b1;
        wcount = 0;
        for (int c = 0; c < 70000 && wcount < 65535; c++) begin
            @(negedge clk);
            if (w_wdone) wcount++;
        end
        check("wrap_count", wcount, 65535);
        check("wrap_ffff", 32'(w_wsent), 32'hFFFF);
        w_enable = 1'b0;
        @(negedge clk);
        check("wrap_done", 32'(w_wdone), 1);
        check("wrap_zero", 32'(w_wsent), 0);
        @(negedge clk);
        check("wrap_idle", 32'(w_dvalid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hamming_tx_scheduler.md
# hamming_tx_scheduler

Transmit-side scheduler for the Hamming link: arbitrates round-robin between `NUM_REQ` word sources and serializes the granted 32-bit word MSB-first onto the encoder's bit-serial input. It drives `data_in`/`data_valid` of the Hamming encoder and honours the encoder's `data_in_ready` backpressure. It runs entirely in the `clk_in` (encoder input) domain.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters (≥2).
- `WORD_W`, 32: bits per word.
- `GAP_CYCLES`, 0: idle `clk_in` cycles inserted after each word (0..255).

Ports:
- `clk_in`  in  1  encoder input-side clock; all logic is on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  when low, no new grants; a word in flight always completes.
- `req_valid`  in  NUM_REQ  requester i has a word pending.
- `req_data`  in  NUM_REQ*WORD_W  word of requester i at `[i*WORD_W +: WORD_W]`.
- `req_ready`  out  NUM_REQ  one-hot accept; word i is taken on the edge where `req_valid[i] && req_ready[i]`.
- `enc_data_in`  out  1  serial bit to encoder `data_in`.
- `enc_data_valid`  out  1  to encoder `data_valid`.
- `enc_data_in_ready`  in  1  from encoder `data_in_ready`; a bit is consumed on an edge where valid and ready are both high.
- `grant_id`  out  $clog2(NUM_REQ)  index of the requester whose word is currently shifting.
- `busy`  out  1  high in SHIFT or GAP.
- `word_done`  out  1  one-cycle pulse after the last bit of a word is consumed.
- `words_sent`  out  16  count of completed words; wraps 0xFFFF→0.

## Operation

- States: IDLE, SHIFT, GAP.
- IDLE:
  - `enc_data_valid`=0.
  - If `enable` is high and any `req_valid` is set, the round-robin winner gets `req_ready` (combinational, one-hot) in the same cycle.
  - On that edge: load the shift register, set `grant_id`, clear the bit counter, go to SHIFT.
- Round-robin:
  - Search starts at `last_grant+1` mod NUM_REQ; `last_grant` updates on every accept.
  - After reset, `last_grant` = NUM_REQ-1, so requester 0 has first priority.
- SHIFT:
  - `enc_data_valid`=1 and `enc_data_in` = shift-register MSB.
  - On each edge with `enc_data_in_ready`=1: shift left by one and increment the bit counter.
  - With ready low, the bit and valid are held unchanged.
- Last bit (counter = WORD_W-1) consumed:
  - Pulse `word_done` and increment `words_sent`.
  - If GAP_CYCLES>0: go to GAP.
  - Else if `enable` and any `req_valid`: arbitrate in the same cycle (`req_ready` asserted while the last bit is consumed), reload, and stay in SHIFT with no bubble.
  - Else: go to IDLE.
- GAP: `enc_data_valid`=0 for exactly GAP_CYCLES cycles, then IDLE.
- `req_ready` is never asserted in GAP, or in SHIFT except in the last-bit back-to-back case.
- `enable` falling mid-word: the word completes, then the block returns to IDLE (via GAP if configured).
- Requester dropping `req_valid` before it is granted: it is simply skipped; no error.

## Timing

- Reset values: `req_ready`=0, `enc_data_in`=0, `enc_data_valid`=0, `grant_id`=0, `busy`=0, `word_done`=0, `words_sent`=0, state IDLE. Reset applies immediately, including mid-word; a partial word is discarded.
- Latency: accept edge → first bit valid in the next cycle.
- Word duration with ready held high: WORD_W cycles. Back-to-back with GAP=0: continuous valid, 32 bits per 32 cycles.
- `word_done` is registered: high in the cycle after the last bit is consumed.
- `words_sent` updates on that same edge.
- `req_ready` depends combinationally on state, `req_valid`, `enable`, `last_grant` and, in SHIFT, `enc_data_in_ready`. There is no combinational path from `req_data`.

## Structure

- Shared package `hamming_link_pkg`:
  - `WORD_W` default.
  - State enum `tx_sched_state_t` (IDLE, SHIFT, GAP).
  - Bit-counter width constant.
- Sub-module `rr_arbiter`:
  - Parameter NUM_REQ.
  - Inputs: `req`, `last_grant`.
  - Outputs: one-hot `grant`, `grant_idx`, `any`.
  - Purely combinational.
- The FSM, shift register, counters and `last_grant` register live in `hamming_tx_scheduler`.

## Test plan

- Single word: requester 0 `req_data`=32'h6748CC61, ready held high → `req_ready[0]` pulses once; `enc_data_in` sequence 0,1,1,0,0,1,1,1,… (MSB first) over 32 cycles; `word_done` once; `words_sent`=1.
- Round-robin: all four requesters valid continuously, GAP=0 → `grant_id` sequence 0,1,2,3,0. `enc_data_valid` stays high for 160 cycles with no bubble.
- Backpressure: `enc_data_in_ready` low for cycles 5–9 of a word → the bit at index 5 is held for 5 cycles and no bit is lost. Completion is delayed by exactly 5 cycles.
- Gap: GAP_CYCLES=3, two queued words → exactly 3 cycles of valid=0 between them, plus one IDLE arbitration cycle.
- Reset mid-word: assert `rst` at bit 17 → all outputs 0 asynchronously. After release, requester 0 has priority again and `words_sent`=0.
- Enable/wrap: `enable` dropped at bit 10 → the word finishes and no new grant follows. Preload `words_sent` to 0xFFFF via 65535 words (or force) → the next `word_done` wraps it to 0.
